cflog_writer: RTL and testbench
===============================

// Module: cflog_writer
// PURPOSE
//  Consumer side of the loop monitor: turns branch events plus loop_detect/loop_ctr into CFLog memory writes.
//  - Each non-loop branch is written as a 2-word record: src, then dest.
//  - Repeated loop branches are suppressed; when the loop exits, one 3-word counter record is written: CTR_TAG, ctr[31:16], ctr[15:0].
//  Sits between the CFA branch/loop monitors and the CFLog RAM. Raises log_full so the TCB can drain the log.
// PARAMETERS
//  ADDR_W     8         CFLog word-address width
//  LOG_DEPTH  256       CFLog capacity in 16-bit words (<= 2**ADDR_W)
//  CTR_SIZE   32        loop_ctr width, fixed at 32
//  CTR_TAG    16'hFFFF  marker word that opens a counter record
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-high reset
//  branch_valid  in   1          one-cycle pulse: a control-flow transfer occurred
//  branch_src    in   16         source PC of the transfer
//  branch_dest   in   16         destination PC of the transfer
//  loop_detect   in   1          loop monitor: a loop is currently active
//  loop_ctr      in   CTR_SIZE   loop monitor iteration counter
//  log_clear     in   1          TCB drained the log: rewind pointer
//  log_wr_en     out  1          CFLog write strobe
//  log_addr      out  ADDR_W     CFLog word address
//  log_wdata     out  16         CFLog write data
//  log_ptr       out  ADDR_W+1   words currently used
//  log_full      out  1          log cannot accept the next record (level)
//  overflow      out  1          sticky: an event was dropped
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE; ptr=0; pending and ctr_hold are cleared.
//  log_clear has the same effect as reset, except overflow is preserved. Reset overrides log_clear.
//  States: IDLE, WR_DST, WR_TAG, WR_CHI, WR_CLO, FULL.
//  log_addr is ptr[ADDR_W-1:0] on every write. ptr increments by 1 per write.
//  Loop tracking:
//   - ld_q is the registered loop_detect.
//   - ctr_hold <= loop_ctr on every cycle where loop_detect==1.
//   - Loop exit is the cycle where ld_q==1 and loop_detect==0; it sets exit_pend.
//  Branch acceptance:
//   - branch_valid with loop_detect==1 and no exit in that cycle: dropped (the loop iteration is counted by the monitor). No write occurs.
//   - Any other branch_valid is captured into a one-entry pending register (src, dest).
//   - If pending is already occupied, the new branch is dropped and overflow is set.
//  Arbitration in IDLE, checked in this order:
//   - exit_pend: required space is 3 words; go to WR_TAG.
//   - else pending: required space is 2 words; go to WR_DST.
//  Space check: if ptr + required space > LOG_DEPTH, go to FULL instead and write nothing.
//  Write sequences:
//   - Branch: the IDLE cycle that starts the record writes src at ptr. WR_DST writes dest at ptr+1, frees pending, returns to IDLE.
//   - Counter: the IDLE cycle writes CTR_TAG. WR_CHI writes ctr_hold[31:16]. WR_CLO writes ctr_hold[15:0], clears exit_pend, returns to IDLE.
//  Latency: a branch_valid in cycle N, with the writer idle and no loop active, gives src written at N+1 and dest at N+2.
//  Simultaneous loop exit and exit branch: the counter record is written first, then the exit branch record, back to back.
//   - Example: exit in cycle N gives writes at N+1..N+3 (counter) and N+4..N+5 (branch).
//  FULL state:
//   - log_full=1; no writes.
//   - New branch/exit events set overflow once pending is occupied.
//   - Leaves FULL only on log_clear or reset.
//  Records are never split across FULL: a record either completes or is not started.
//  A new loop exit while exit_pend is still set drops that exit and sets overflow.
// TESTING
//  1. Reset, then branch_valid src=16'hE010 dest=16'hE100 -> writes (0:E010),(1:E100); log_ptr=2.
//  2. loop_detect high for 5 branches with loop_ctr reaching 32'h0000_0006, then falls at the same time as branch E120->E200
//     -> no writes during the loop; then (2:FFFF),(3:0000),(4:0006),(5:E120),(6:E200).
//  3. LOG_DEPTH=4 with ptr=3, then a branch -> no write, log_full=1; log_clear -> log_ptr=0, log_full=0.
//  4. Two branches 1 cycle apart while in WR_DST, then a third -> two records written in order; third dropped, overflow=1.
//  5. reset asserted during WR_CHI -> all outputs 0 next cycle; no further writes; ctr_hold cleared.
//  6. loop_ctr=32'hABCD_1234 at exit -> record words FFFF, ABCD, 1234 at consecutive addresses.

Source files
------------

// File: rtl/cflog_writer.sv
// Turns branch events and loop-monitor status into CFLog word writes:
// two-word branch records and three-word loop-counter records.
module cflog_writer #(
  parameter int          ADDR_W    = 8,
  parameter int          LOG_DEPTH = 256,
  parameter int          CTR_SIZE  = 32,
  parameter logic [15:0] CTR_TAG   = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                branch_valid,
  input  logic [15:0]         branch_src,
  input  logic [15:0]         branch_dest,
  input  logic                loop_detect,
  input  logic [CTR_SIZE-1:0] loop_ctr,
  input  logic                log_clear,
  output logic                log_wr_en,
  output logic [ADDR_W-1:0]   log_addr,
  output logic [15:0]         log_wdata,
  output logic [ADDR_W:0]     log_ptr,
  output logic                log_full,
  output logic                overflow
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WR_DST = 3'd1;
  localparam logic [2:0] WR_TAG = 3'd2;
  localparam logic [2:0] WR_CHI = 3'd3;
  localparam logic [2:0] WR_CLO = 3'd4;
  localparam logic [2:0] FULL   = 3'd5;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(LOG_DEPTH);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                ld_q, ld_d;
  logic [CTR_SIZE-1:0] ctr_hold_q, ctr_hold_d;
  logic                exit_pend_q, exit_pend_d;
  logic                pend_v_q, pend_v_d;
  logic [15:0]         pend_src_q, pend_src_d;
  logic [15:0]         pend_dst_q, pend_dst_d;
  logic                overflow_q, overflow_d;

  logic                wr_en;
  logic [15:0]         wr_data;
  logic [ADDR_W+1:0]   ptr_ext;
  logic                fit2, fit3;
  logic                loop_exit;
  logic                br_take;
  logic                pend_busy;
  logic                exit_busy;

  assign ptr_ext   = {1'b0, ptr_q};
  assign fit2      = (ptr_ext + (ADDR_W+2)'(2)) <= DEPTH_W;
  assign fit3      = (ptr_ext + (ADDR_W+2)'(3)) <= DEPTH_W;
  assign loop_exit = ld_q && !loop_detect;
  // Branches inside an active loop are counted by the loop monitor instead.
  assign br_take   = branch_valid && !loop_detect;
  // A slot being released this cycle can take a new event at the same edge.
  assign pend_busy = pend_v_q && (state_q != WR_DST);
  assign exit_busy = exit_pend_q && (state_q != WR_CLO);

  always_comb begin
    state_d     = state_q;
    ld_d        = loop_detect;
    ctr_hold_d  = ctr_hold_q;
    exit_pend_d = exit_pend_q;
    pend_v_d    = pend_v_q;
    pend_src_d  = pend_src_q;
    pend_dst_d  = pend_dst_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    wr_data     = 16'h0000;

    case (state_q)
      IDLE: begin
        if (exit_pend_q) begin
          if (fit3) begin
            wr_en   = 1'b1;
            wr_data = CTR_TAG;
            state_d = WR_CHI;
          end else begin
            state_d = FULL;
          end
        end else if (pend_v_q) begin
          if (fit2) begin
            wr_en   = 1'b1;
            wr_data = pend_src_q;
            state_d = WR_DST;
          end else begin
            state_d = FULL;
          end
        end
      end
      // The tag word is emitted from IDLE, so WR_TAG behaves like WR_CHI.
      WR_TAG, WR_CHI: begin
        wr_en   = 1'b1;
        wr_data = ctr_hold_q[31:16];
        state_d = WR_CLO;
      end
      WR_CLO: begin
        wr_en       = 1'b1;
        wr_data     = ctr_hold_q[15:0];
        exit_pend_d = 1'b0;
        state_d     = IDLE;
      end
      WR_DST: begin
        wr_en    = 1'b1;
        wr_data  = pend_dst_q;
        pend_v_d = 1'b0;
        state_d  = IDLE;
      end
      FULL:    state_d = FULL;
      default: state_d = IDLE;
    endcase

    if (loop_detect) ctr_hold_d = loop_ctr;

    if (br_take) begin
      if (pend_busy) begin
        overflow_d = 1'b1;
      end else begin
        pend_v_d   = 1'b1;
        pend_src_d = branch_src;
        pend_dst_d = branch_dest;
      end
    end

    if (loop_exit) begin
      if (exit_busy) overflow_d  = 1'b1;
      else           exit_pend_d = 1'b1;
    end
  end

  assign ptr_d = ptr_q + {{ADDR_W{1'b0}}, wr_en};

  always_ff @(posedge clk) begin
    if (reset || log_clear) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ld_q        <= 1'b0;
      ctr_hold_q  <= '0;
      exit_pend_q <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_src_q  <= '0;
      pend_dst_q  <= '0;
      overflow_q  <= reset ? 1'b0 : overflow_q;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_q        <= ld_d;
      ctr_hold_q  <= ctr_hold_d;
      exit_pend_q <= exit_pend_d;
      pend_v_q    <= pend_v_d;
      pend_src_q  <= pend_src_d;
      pend_dst_q  <= pend_dst_d;
      overflow_q  <= overflow_d;
    end
  end

  assign log_wr_en = wr_en;
  assign log_addr  = ptr_q[ADDR_W-1:0];
  assign log_wdata = wr_data;
  assign log_ptr   = ptr_q;
  assign log_full  = (state_q == FULL);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Directed bench for cflog_writer: expected CFLog writes are queued when
// stimulus is driven and matched against every observed write strobe.
module tb_cflog_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_src = '0;
  logic [15:0] branch_dest = '0;
  logic        loop_detect = 1'b0;
  logic [31:0] loop_ctr = '0;
  logic        log_clear = 1'b0;
  logic        log_wr_en;
  logic [7:0]  log_addr;
  logic [15:0] log_wdata;
  logic [8:0]  log_ptr;
  logic        log_full;
  logic        overflow;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;

  cflog_writer #(.ADDR_W(8), .LOG_DEPTH(256), .CTR_SIZE(32), .CTR_TAG(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .branch_valid(branch_valid), .branch_src(branch_src),
    .branch_dest(branch_dest), .loop_detect(loop_detect), .loop_ctr(loop_ctr),
    .log_clear(log_clear), .log_wr_en(log_wr_en), .log_addr(log_addr),
    .log_wdata(log_wdata), .log_ptr(log_ptr), .log_full(log_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic branch(input logic [15:0] s, input logic [15:0] d);
    branch_valid = 1'b1;
    branch_src   = s;
    branch_dest  = d;
    step();
    branch_valid = 1'b0;
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (log_wr_en) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected none", log_addr, log_wdata);
      end
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {24'h0, log_addr}, {24'h0, e.a});
        chk("wr_data", {16'h0, log_wdata}, {16'h0, e.d});
        $display("write addr=%h data=%h", log_addr, log_wdata);
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    @(negedge clk);
    chk("rst_wr_en", {31'h0, log_wr_en}, 32'h0);
    chk("rst_addr", {24'h0, log_addr}, 32'h0);
    chk("rst_wdata", {16'h0, log_wdata}, 32'h0);
    chk("rst_ptr", {23'h0, log_ptr}, 32'h0);
    chk("rst_full", {31'h0, log_full}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single branch record
    push(8'd0, 16'hE010);
    push(8'd1, 16'hE100);
    branch(16'hE010, 16'hE100);
    step(3);
    chk("t1_ptr", {23'h0, log_ptr}, 32'd2);

    // Loop with suppressed branches, exit coincident with a branch
    for (int i = 1; i <= 6; i++) begin
      loop_detect  = 1'b1;
      loop_ctr     = 32'(i);
      branch_valid = (i <= 5);
      branch_src   = 16'hE120;
      branch_dest  = 16'hE110;
      step();
    end
    push(8'd2, 16'hFFFF);
    push(8'd3, 16'h0000);
    push(8'd4, 16'h0006);
    push(8'd5, 16'hE120);
    push(8'd6, 16'hE200);
    loop_detect = 1'b0;
    loop_ctr    = 32'd7;
    branch(16'hE120, 16'hE200);
    step(7);
    chk("t2_ptr", {23'h0, log_ptr}, 32'd7);
    chk("t2_ovf", {31'h0, overflow}, 32'h0);

    // Counter record carrying both halves
    loop_detect = 1'b1;
    loop_ctr    = 32'hABCD_1234;
    step();
    push(8'd7, 16'hFFFF);
    push(8'd8, 16'hABCD);
    push(8'd9, 16'h1234);
    loop_detect = 1'b0;
    loop_ctr    = 32'h0;
    step(6);
    chk("t6_ptr", {23'h0, log_ptr}, 32'd10);

    // Back-to-back branches; the third finds pending occupied
    push(8'd10, 16'hF000);
    push(8'd11, 16'hF001);
    push(8'd12, 16'hF002);
    push(8'd13, 16'hF003);
    branch(16'hF000, 16'hF001);
    step();
    branch(16'hF002, 16'hF003);
    branch(16'hF004, 16'hF005);
    step(6);
    chk("t4_ovf", {31'h0, overflow}, 32'h1);
    chk("t4_ptr", {23'h0, log_ptr}, 32'd14);

    // Reset in the middle of a counter record
    push(8'd14, 16'hFFFF);
    push(8'd15, 16'h0000);
    loop_detect = 1'b1;
    loop_ctr    = 32'h0000_0055;
    step();
    loop_detect = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t5_wr_en", {31'h0, log_wr_en}, 32'h0);
    chk("t5_ptr", {23'h0, log_ptr}, 32'h0);
    chk("t5_wdata", {16'h0, log_wdata}, 32'h0);
    chk("t5_ovf", {31'h0, overflow}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(5);
    chk("t5_ptr_after", {23'h0, log_ptr}, 32'h0);

    // Fill to 255 words, then a 2-word record must not fit
    push(8'd0, 16'hFFFF);
    push(8'd1, 16'h0000);
    push(8'd2, 16'h0077);
    loop_detect = 1'b1;
    loop_ctr    = 32'h77;
    step();
    loop_detect = 1'b0;
    step(4);
    for (int k = 0; k < 126; k++) begin
      push(8'(3 + 2 * k), 16'h1000 + 16'(k));
      push(8'(4 + 2 * k), 16'h2000 + 16'(k));
      branch(16'h1000 + 16'(k), 16'h2000 + 16'(k));
      step();
    end
    step(3);
    chk("t3_ptr_255", {23'h0, log_ptr}, 32'd255);
    chk("t3_full_pre", {31'h0, log_full}, 32'h0);
    branch(16'hDEAD, 16'hBEEF);
    step(2);
    chk("t3_full", {31'h0, log_full}, 32'h1);
    chk("t3_ptr_held", {23'h0, log_ptr}, 32'd255);
    chk("t3_ovf_pre", {31'h0, overflow}, 32'h0);
    branch(16'hDEAD, 16'hBEEF);
    step();
    chk("t3_ovf", {31'h0, overflow}, 32'h1);
    log_clear = 1'b1;
    step();
    log_clear = 1'b0;
    @(negedge clk);
    chk("t3_clr_ptr", {23'h0, log_ptr}, 32'h0);
    chk("t3_clr_full", {31'h0, log_full}, 32'h0);
    chk("t3_clr_ovf", {31'h0, overflow}, 32'h1);
    @(posedge clk); #1;
    push(8'd0, 16'hC0DE);
    push(8'd1, 16'hC0DF);
    branch(16'hC0DE, 16'hC0DF);
    step(4);
    chk("t3_post_ptr", {23'h0, log_ptr}, 32'd2);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
